// File: rtl/nor_seq_pkg.sv
// rtl/nor_seq_pkg.sv - shared types, step counts and micro-program ROM for nor_seq
package nor_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOR  = 3'd0,
    OP_NOT  = 3'd1,
    OP_OR   = 3'd2,
    OP_AND  = 3'd3,
    OP_NAND = 3'd4,
    OP_XNOR = 3'd5,
    OP_XOR  = 3'd6,
    OP_RSV  = 3'd7
  } op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T0, SRC_T1, SRC_T2} src_e;

  typedef enum logic [1:0] {DST_T0, DST_T1, DST_T2, DST_Y} dst_e;

  typedef struct packed {
    src_e src_a;
    src_e src_b;
    dst_e dst;
    logic last;
  } uop_t;

  localparam logic [2:0] L_NOR  = 3'd1;
  localparam logic [2:0] L_NOT  = 3'd1;
  localparam logic [2:0] L_OR   = 3'd2;
  localparam logic [2:0] L_AND  = 3'd3;
  localparam logic [2:0] L_NAND = 3'd4;
  localparam logic [2:0] L_XNOR = 3'd4;
  localparam logic [2:0] L_XOR  = 3'd5;

  function automatic logic [2:0] op_len(input op_e op);
    case (op)
      OP_NOR:  return L_NOR;
      OP_NOT:  return L_NOT;
      OP_OR:   return L_OR;
      OP_AND:  return L_AND;
      OP_NAND: return L_NAND;
      OP_XNOR: return L_XNOR;
      OP_XOR:  return L_XOR;
      default: return 3'd1;
    endcase
  endfunction

  function automatic uop_t mk(input src_e s_a, input src_e s_b, input dst_e d);
    uop_t u;
    u.src_a = s_a;
    u.src_b = s_b;
    u.dst   = d;
    u.last  = 1'b0;
    return u;
  endfunction

  // Every program writes a temporary before it reads it, so temps never need clearing.
  function automatic uop_t uop_rom(input op_e op, input logic [2:0] step);
    uop_t u;
    u = mk(SRC_A, SRC_A, DST_Y);
    case (op)
      OP_NOR: u = mk(SRC_A, SRC_B, DST_Y);
      OP_NOT: u = mk(SRC_A, SRC_A, DST_Y);
      OP_OR:
        case (step)
          3'd0:    u = mk(SRC_A, SRC_B, DST_T0);
          default: u = mk(SRC_T0, SRC_T0, DST_Y);
        endcase
      OP_AND, OP_NAND:
        case (step)
          3'd0:    u = mk(SRC_A, SRC_A, DST_T0);
          3'd1:    u = mk(SRC_B, SRC_B, DST_T1);
          3'd2:    u = mk(SRC_T0, SRC_T1, (op == OP_AND) ? DST_Y : DST_T2);
          default: u = mk(SRC_T2, SRC_T2, DST_Y);
        endcase
      OP_XNOR, OP_XOR:
        case (step)
          3'd0:    u = mk(SRC_A, SRC_B, DST_T0);
          3'd1:    u = mk(SRC_A, SRC_T0, DST_T1);
          3'd2:    u = mk(SRC_B, SRC_T0, DST_T2);
          3'd3:    u = mk(SRC_T1, SRC_T2, (op == OP_XNOR) ? DST_Y : DST_T0);
          default: u = mk(SRC_T0, SRC_T0, DST_Y);
        endcase
      default: u = mk(SRC_A, SRC_A, DST_Y);
    endcase
    u.last = (step == (op_len(op) - 3'd1));
    return u;
  endfunction

endpackage

// File: rtl/dnor.sv
// rtl/dnor.sv - single-bit 2-input NOR cell
module dnor (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);

  assign o_y = ~(i_a | i_b);

endmodule

// File: rtl/nor_seq_nor_vec.sv
// rtl/nor_seq_nor_vec.sv - WIDTH-bit bitwise NOR array built from dnor cells
module nor_vec #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_bit
      dnor u_dnor (
        .i_a (i_a[g]),
        .i_b (i_b[g]),
        .o_y (o_y[g])
      );
    end
  endgenerate

endmodule

// File: rtl/nor_seq.sv
// rtl/nor_seq.sv - micro-sequenced logic unit on one shared NOR array; NOR_SEQ_PERF_EN adds busy_cycles
module nor_seq
  import nor_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err
`ifdef NOR_SEQ_PERF_EN
  ,
  output logic [31:0]      busy_cycles
`endif
);

  state_e           r_state;
  state_e           w_next;
  op_e              r_op;
  logic [2:0]       r_step;
  logic [WIDTH-1:0] r_a, r_b, r_t0, r_t1, r_t2, r_y;
  logic             r_err;
  uop_t             w_uop;
  logic [WIDTH-1:0] w_src_a, w_src_b, w_nor;
  logic             w_accept;

  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_uop     = uop_rom(r_op, r_step);
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign y         = r_y;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Reserved opcode spends one RUN cycle so its latency matches a 1-step program.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (in_valid) w_next = ST_RUN;
      ST_RUN:  if (r_op == OP_RSV || w_uop.last) w_next = ST_DONE;
      ST_DONE: if (out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_src_a = r_a;
    case (w_uop.src_a)
      SRC_A:   w_src_a = r_a;
      SRC_B:   w_src_a = r_b;
      SRC_T0:  w_src_a = r_t0;
      SRC_T1:  w_src_a = r_t1;
      SRC_T2:  w_src_a = r_t2;
      default: w_src_a = r_a;
    endcase
  end

  always_comb begin
    w_src_b = r_b;
    case (w_uop.src_b)
      SRC_A:   w_src_b = r_a;
      SRC_B:   w_src_b = r_b;
      SRC_T0:  w_src_b = r_t0;
      SRC_T1:  w_src_b = r_t1;
      SRC_T2:  w_src_b = r_t2;
      default: w_src_b = r_b;
    endcase
  end

  nor_vec #(.WIDTH(WIDTH)) u_nor_vec (
    .i_a (w_src_a),
    .i_b (w_src_b),
    .o_y (w_nor)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_NOR;
      r_step <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_t0   <= '0;
      r_t1   <= '0;
      r_t2   <= '0;
      r_y    <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_op   <= op_e'(op);
      r_step <= '0;
    end else if (r_state == ST_RUN) begin
      r_step <= r_step + 3'd1;
      if (r_op == OP_RSV) begin
        r_y   <= '0;
        r_err <= 1'b1;
      end else begin
        case (w_uop.dst)
          DST_T0: r_t0 <= w_nor;
          DST_T1: r_t1 <= w_nor;
          DST_T2: r_t2 <= w_nor;
          default: begin
            r_y   <= w_nor;
            r_err <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef NOR_SEQ_PERF_EN
  logic [31:0] r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_busy <= '0;
    else if (r_state == ST_RUN && r_busy != '1)      r_busy <= r_busy + 32'd1;
  end

  assign busy_cycles = r_busy;
`endif

endmodule

// File: tb/tb_nor_seq.sv
// tb/tb_nor_seq.sv - scoreboard bench for nor_seq; NOR_SEQ_PERF_EN also checks busy_cycles
module tb_nor_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] y;
  logic       err;
`ifdef NOR_SEQ_PERF_EN
  logic [31:0] busy_cycles;
`endif

  typedef struct {
    logic [7:0] y;
    logic       err;
    int         lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  nor_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .err       (err)
`ifdef NOR_SEQ_PERF_EN
    ,
    .busy_cycles (busy_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    exp_t e;
    e.err = 1'b0;
    case (o)
      3'd0: begin e.y = ~(x | z); e.lat = 1; end
      3'd1: begin e.y = ~x;       e.lat = 1; end
      3'd2: begin e.y = x | z;    e.lat = 2; end
      3'd3: begin e.y = x & z;    e.lat = 3; end
      3'd4: begin e.y = ~(x & z); e.lat = 4; end
      3'd5: begin e.y = ~(x ^ z); e.lat = 4; end
      3'd6: begin e.y = x ^ z;    e.lat = 5; end
      default: begin e.y = 8'h00; e.err = 1'b1; e.lat = 1; end
    endcase
    return e;
  endfunction

  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    int n;
    @(negedge clk);
    op = o; a = x; b = z; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    q.push_back(model(o, x, z));
    #1;
    in_valid = 1'b0;
    op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
  endtask

  task automatic collect(input int hold);
    int   edges;
    exp_t e;
    logic [7:0] y_seen;
    out_ready = (hold == 0);
    @(negedge clk);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    edges = 0;
    while (!out_valid && edges < 30) begin
      @(negedge clk);
      edges++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 32'd0, 32'd1);
      return;
    end
    if (q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = q.pop_front();
    check("y", 32'(y), 32'(e.y));
    check("err", 32'(err), 32'(e.err));
    check("latency", edges, e.lat);
    y_seen = y;
    for (int i = 0; i < hold; i++) begin
      op = 3'd0; a = 8'h00; b = 8'h00; in_valid = 1'b1;
      @(negedge clk);
      check("hold_y", 32'(y), 32'(y_seen));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_err", 32'(err), 32'd0);
`ifdef NOR_SEQ_PERF_EN
    check("rst_busy", busy_cycles, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(3'd3, 8'hF0, 8'h3C); collect(0);
    send(3'd6, 8'hA5, 8'hFF); collect(0);
    send(3'd5, 8'hA5, 8'hFF); collect(0);
    send(3'd2, 8'h0F, 8'h30); collect(0);
    send(3'd7, 8'hFF, 8'hFF); collect(0);
    send(3'd0, 8'h00, 8'h00); collect(0);
    send(3'd4, 8'hFF, 8'h0F); collect(4);

    send(3'd5, 8'h3C, 8'h96);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_y", 32'(y), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    send(3'd1, 8'h81, 8'h00); collect(0);

    for (int i = 0; i < 16; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
      collect(int'($urandom_range(0, 2)));
    end

`ifdef NOR_SEQ_PERF_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(3'd3, 8'hF0, 8'h3C); collect(0);
    send(3'd6, 8'hA5, 8'hFF); collect(0);
    check("busy_cycles", busy_cycles, 32'd8);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("busy_after_rst", busy_cycles, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
